// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the stall/flush controller and the forwarding unit.
package hazard_stall_unit_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hsu_state_t;

   // Register index that never carries a dependence.
   localparam int unsigned ZERO_ADDRESS = 0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q;
   logic [Width-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller beside ID: freezes PC and IF/ID on hazards forwarding cannot cover,
// bubbles ID/EX, flushes IF/ID on taken branches, and counts both events.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned AddressSize = 5,
   parameter int unsigned CntWidth    = 16
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic [AddressSize-1:0] IDRs1,
   input  logic [AddressSize-1:0] IDRs2,
   input  logic                   IDUsesRs1,
   input  logic                   IDUsesRs2,
   input  logic                   IDIsBranch,
   input  logic [AddressSize-1:0] EXRegisterRd,
   input  logic                   EXMemRead,
   input  logic                   EXRegWrite,
   input  logic [AddressSize-1:0] MemRegisterRd,
   input  logic                   MemMemRead,
   input  logic                   branchTaken,
   output logic                   PCWrite,
   output logic                   IFIDWrite,
   output logic                   IDEXBubble,
   output logic                   IFIDFlush,
   output logic [CntWidth-1:0]    stallCount,
   output logic [CntWidth-1:0]    flushCount
);

   localparam logic [AddressSize-1:0] ZeroAddr = AddressSize'(ZERO_ADDRESS);

   hsu_state_t state_q;
   hsu_state_t state_d;

   logic ex_match;
   logic mem_match;
   logic h1;
   logic h2;
   logic stall;
   logic flush;

   // Dependence on an older producer; x0 is hard-wired and never matches.
   always_comb begin
      ex_match  = (EXRegisterRd != ZeroAddr) &&
                  ((IDUsesRs1 && (IDRs1 == EXRegisterRd)) ||
                   (IDUsesRs2 && (IDRs2 == EXRegisterRd)));
      mem_match = (MemRegisterRd != ZeroAddr) &&
                  ((IDUsesRs1 && (IDRs1 == MemRegisterRd)) ||
                   (IDUsesRs2 && (IDRs2 == MemRegisterRd)));
   end

   always_comb begin
      h2 = IDIsBranch && EXMemRead && ex_match;
      h1 = (!IDIsBranch && EXMemRead && ex_match) ||
           (IDIsBranch && EXRegWrite && !EXMemRead && ex_match) ||
           (IDIsBranch && MemMemRead && mem_match);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:  state_d = h2 ? HOLD : RUN;
         HOLD: state_d = RUN;
      endcase
   end

   // HOLD is the registered second cycle of a load-feeding-branch stall.
   always_comb begin
      stall = 1'b0;
      unique case (state_q)
         RUN:  stall = h1 || h2;
         HOLD: stall = 1'b1;
      endcase
      if (arst) begin
         stall = 1'b0;
      end
   end

   // A taken branch seen during a stall is re-presented once the stall clears.
   assign flush      = !arst && branchTaken && !stall;
   assign PCWrite    = !stall;
   assign IFIDWrite  = !stall;
   assign IDEXBubble = stall;
   assign IFIDFlush  = flush;

   sat_counter #(
      .Width (CntWidth)
   ) u_stall_cnt (
      .clk   (clk),
      .arst  (arst),
      .inc   (stall),
      .count (stallCount)
   );

   sat_counter #(
      .Width (CntWidth)
   ) u_flush_cnt (
      .clk   (clk),
      .arst  (arst),
      .inc   (flush),
      .count (flushCount)
   );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit; a narrow-counter copy covers saturation.
module tb_hazard_stall_unit;

   logic       clk;
   logic       arst;
   logic [4:0] IDRs1, IDRs2, EXRegisterRd, MemRegisterRd;
   logic       IDUsesRs1, IDUsesRs2, IDIsBranch, EXMemRead, EXRegWrite, MemMemRead, branchTaken;

   logic        PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
   logic [15:0] stallCount, flushCount;
   logic        s_pcwrite, s_ifidwrite, s_bubble, s_flush;
   logic [2:0]  s_stall_cnt, s_flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_stall_unit dut (
      .clk           (clk),
      .arst          (arst),
      .IDRs1         (IDRs1),
      .IDRs2         (IDRs2),
      .IDUsesRs1     (IDUsesRs1),
      .IDUsesRs2     (IDUsesRs2),
      .IDIsBranch    (IDIsBranch),
      .EXRegisterRd  (EXRegisterRd),
      .EXMemRead     (EXMemRead),
      .EXRegWrite    (EXRegWrite),
      .MemRegisterRd (MemRegisterRd),
      .MemMemRead    (MemMemRead),
      .branchTaken   (branchTaken),
      .PCWrite       (PCWrite),
      .IFIDWrite     (IFIDWrite),
      .IDEXBubble    (IDEXBubble),
      .IFIDFlush     (IFIDFlush),
      .stallCount    (stallCount),
      .flushCount    (flushCount)
   );

   hazard_stall_unit #(
      .AddressSize (5),
      .CntWidth    (3)
   ) dut_sat (
      .clk           (clk),
      .arst          (arst),
      .IDRs1         (IDRs1),
      .IDRs2         (IDRs2),
      .IDUsesRs1     (IDUsesRs1),
      .IDUsesRs2     (IDUsesRs2),
      .IDIsBranch    (IDIsBranch),
      .EXRegisterRd  (EXRegisterRd),
      .EXMemRead     (EXMemRead),
      .EXRegWrite    (EXRegWrite),
      .MemRegisterRd (MemRegisterRd),
      .MemMemRead    (MemMemRead),
      .branchTaken   (branchTaken),
      .PCWrite       (s_pcwrite),
      .IFIDWrite     (s_ifidwrite),
      .IDEXBubble    (s_bubble),
      .IFIDFlush     (s_flush),
      .stallCount    (s_stall_cnt),
      .flushCount    (s_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      IDRs1 = '0; IDRs2 = '0; EXRegisterRd = '0; MemRegisterRd = '0;
      IDUsesRs1 = 1'b0; IDUsesRs2 = 1'b0; IDIsBranch = 1'b0;
      EXMemRead = 1'b0; EXRegWrite = 1'b0; MemMemRead = 1'b0; branchTaken = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic stall_exp, input logic flush_exp);
      chk({tag, "_pcwrite"}, {31'b0, PCWrite}, {31'b0, !stall_exp});
      chk({tag, "_ifidwrite"}, {31'b0, IFIDWrite}, {31'b0, !stall_exp});
      chk({tag, "_bubble"}, {31'b0, IDEXBubble}, {31'b0, stall_exp});
      chk({tag, "_flush"}, {31'b0, IFIDFlush}, {31'b0, flush_exp});
   endtask

   initial begin
      // Reset with a live load-use hazard on the inputs: outputs must stay masked.
      clear_inputs();
      arst = 1'b1;
      EXMemRead = 1'b1; EXRegisterRd = 5'd5; IDRs1 = 5'd5; IDUsesRs1 = 1'b1; branchTaken = 1'b1;
      @(negedge clk);
      chk_ctl("reset_mask", 1'b0, 1'b0);
      chk("reset_stallcnt", 32'(stallCount), 32'd0);
      chk("reset_flushcnt", 32'(flushCount), 32'd0);
      tick();
      arst = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk_ctl("idle", 1'b0, 1'b0);

      // 1: lw x5 in EX, add reading x5 in ID
      tick();
      EXMemRead = 1'b1; EXRegisterRd = 5'd5; IDRs1 = 5'd5; IDUsesRs1 = 1'b1;
      @(negedge clk);
      chk_ctl("loaduse", 1'b1, 1'b0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk_ctl("loaduse_after", 1'b0, 1'b0);
      chk("loaduse_cnt", 32'(stallCount), 32'd1);

      // Same register index but the ID instruction does not read it
      tick();
      EXMemRead = 1'b1; EXRegisterRd = 5'd5; IDRs1 = 5'd5; IDUsesRs1 = 1'b0;
      @(negedge clk);
      chk_ctl("unused_rs1", 1'b0, 1'b0);

      // 2: lw x5 in EX, beq reading x5 via rs2 -> RUN stall then HOLD stall
      tick();
      clear_inputs();
      EXMemRead = 1'b1; EXRegisterRd = 5'd5; IDIsBranch = 1'b1; IDRs2 = 5'd5; IDUsesRs2 = 1'b1;
      @(negedge clk);
      chk_ctl("h2_run", 1'b1, 1'b0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk_ctl("h2_hold", 1'b1, 1'b0);
      chk("h2_hold_cnt", 32'(stallCount), 32'd2);
      tick();
      @(negedge clk);
      chk_ctl("h2_done", 1'b0, 1'b0);
      chk("h2_done_cnt", 32'(stallCount), 32'd3);

      // 3: ALU result feeding a branch compare; x0 never matches
      tick();
      EXRegWrite = 1'b1; EXRegisterRd = 5'd7; IDIsBranch = 1'b1; IDRs1 = 5'd7; IDUsesRs1 = 1'b1;
      @(negedge clk);
      chk_ctl("alu_branch", 1'b1, 1'b0);
      tick();
      EXRegisterRd = 5'd0; IDRs1 = 5'd0;
      @(negedge clk);
      chk_ctl("alu_branch_x0", 1'b0, 1'b0);
      chk("alu_branch_cnt", 32'(stallCount), 32'd4);
      tick();
      EXRegisterRd = 5'd7; IDRs1 = 5'd7; IDIsBranch = 1'b0;
      @(negedge clk);
      chk_ctl("alu_nonbranch", 1'b0, 1'b0);

      // 4: load in MEM feeding a branch; a non-branch user is forwarded
      tick();
      clear_inputs();
      MemMemRead = 1'b1; MemRegisterRd = 5'd3; IDIsBranch = 1'b1; IDRs1 = 5'd3; IDUsesRs1 = 1'b1;
      @(negedge clk);
      chk_ctl("mem_branch", 1'b1, 1'b0);
      tick();
      IDIsBranch = 1'b0;
      @(negedge clk);
      chk_ctl("mem_nonbranch", 1'b0, 1'b0);
      chk("mem_cnt", 32'(stallCount), 32'd5);

      // 5: taken branch flushes; ignored while a stall is raised
      tick();
      clear_inputs();
      branchTaken = 1'b1;
      @(negedge clk);
      chk_ctl("flush", 1'b0, 1'b1);
      tick();
      clear_inputs();
      @(negedge clk);
      chk_ctl("flush_after", 1'b0, 1'b0);
      chk("flush_cnt", 32'(flushCount), 32'd1);
      tick();
      branchTaken = 1'b1; EXMemRead = 1'b1; EXRegisterRd = 5'd5; IDRs1 = 5'd5; IDUsesRs1 = 1'b1;
      @(negedge clk);
      chk_ctl("flush_stalled", 1'b1, 1'b0);
      tick();
      clear_inputs();
      @(negedge clk);
      chk("flush_stalled_fcnt", 32'(flushCount), 32'd1);
      chk("flush_stalled_scnt", 32'(stallCount), 32'd6);

      // 6: reset pulse while in HOLD aborts the second stall cycle
      tick();
      EXMemRead = 1'b1; EXRegisterRd = 5'd9; IDIsBranch = 1'b1; IDRs1 = 5'd9; IDUsesRs1 = 1'b1;
      tick();
      clear_inputs();
      @(negedge clk);
      chk_ctl("hold_pre_reset", 1'b1, 1'b0);
      arst = 1'b1;
      #1;
      chk_ctl("hold_in_reset", 1'b0, 1'b0);
      chk("hold_reset_scnt", 32'(stallCount), 32'd0);
      chk("hold_reset_fcnt", 32'(flushCount), 32'd0);
      tick();
      arst = 1'b0;
      @(negedge clk);
      chk_ctl("post_reset_run", 1'b0, 1'b0);
      chk("post_reset_scnt", 32'(stallCount), 32'd0);

      // Saturation: narrow counter pins at 7 while the wide one keeps counting
      tick();
      EXMemRead = 1'b1; EXRegisterRd = 5'd4; IDRs2 = 5'd4; IDUsesRs2 = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      clear_inputs();
      @(negedge clk);
      chk("sat_narrow", 32'(s_stall_cnt), 32'd7);
      chk("sat_wide", 32'(stallCount), 32'd9);
      chk("sat_flush", 32'(s_flush_cnt), 32'd0);
      tick();
      @(negedge clk);
      chk("sat_hold", 32'(s_stall_cnt), 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
